// File: rtl/booth_layer_accum.sv
// booth_layer_accum: serial radix-4 Booth multiplier, one 2-bit multiplier slice
// per cycle, exact 2*WIDTH-bit signed product over a valid/ready handshake.
module booth_layer_accum #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     product,
    output logic                   busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned NSL   = WIDTH / 2;
    localparam int unsigned IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH:0]       bext_q, bext_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [IDX_W:0]       shamt;
    logic [2:0]           digit;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        pp;

    // State register plus registered handshake/status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; leaves RUN only after the last slice
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)            state_d = S_RUN;
            S_RUN:  if (idx_q == LAST_IDX)   state_d = S_DONE;
            S_DONE: if (out_ready)           state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // Status flags decoded from the upcoming state so they register with it
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // Booth digit for the current slice and its sign-extended partial product
    always_comb begin
        shamt = {idx_q, 1'b0};
        digit = bext_q[shamt +: 3];
        a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        case (digit)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = PW'(-(a_ext << 1));
            3'b101, 3'b110: pp = PW'(-a_ext);
            default:        pp = '0;
        endcase
    end

    // Operand capture and layer accumulation
    always_comb begin
        a_d    = a_q;
        bext_d = bext_q;
        acc_d  = acc_q;
        idx_d  = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    bext_d = {b, 1'b0};
                    acc_d  = '0;
                    idx_d  = '0;
                end
            end
            S_RUN: begin
                acc_d = acc_q + (pp << shamt);
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            bext_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
        end else begin
            a_q    <= a_d;
            bext_q <= bext_d;
            acc_q  <= acc_d;
            idx_q  <= idx_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = acc_q;

endmodule
